// File: rtl/tilelink_pkg.sv
// Shared TL-UL widths, channel payload structs and arbiter FSM state type.
package tilelink_pkg;

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned PARAM_WIDTH  = 3;
  localparam int unsigned SIZE_WIDTH   = 3;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned MASK_WIDTH   = 4;
  localparam int unsigned SINK_WIDTH   = 1;

  // Source field = {host index, host-local source}; sized for the default 3-host build.
  localparam int unsigned TL_HOST_SRC_WIDTH = 1;
  localparam int unsigned TL_IDX_W          = 2;
  localparam int unsigned TL_SOURCE_WIDTH   = TL_HOST_SRC_WIDTH + TL_IDX_W;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [PARAM_WIDTH-1:0]     param;
    logic [SIZE_WIDTH-1:0]      size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [ADDR_WIDTH-1:0]      address;
    logic [MASK_WIDTH-1:0]      mask;
    logic [DATA_WIDTH-1:0]      data;
  } tl_a_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [PARAM_WIDTH-1:0]     param;
    logic [SIZE_WIDTH-1:0]      size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [SINK_WIDTH-1:0]      sink;
    logic [DATA_WIDTH-1:0]      data;
    logic                       error;
  } tl_d_t;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, searching cyclically.
module tl_rr_picker #(
  parameter int unsigned NUM_HOSTS = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_HOSTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 any_valid
);

  logic [IDX_W:0] cand;

  // Walk NUM_HOSTS candidates from rr_ptr, keeping the first requester found.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_HOSTS)) begin
        cand = cand - (IDX_W + 1)'(NUM_HOSTS);
      end
      if (!any_valid && req[cand[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        idx       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tilelink_host_arbiter.sv
// N-host TL-UL arbiter: round-robin A-channel grant with one bubble per beat,
// in-flight credit limit, and zero-latency D-channel routing by source MSBs.
module tilelink_host_arbiter
  import tilelink_pkg::*;
#(
  parameter int unsigned NUM_HOSTS       = 3,
  parameter int unsigned HOST_SRC_WIDTH  = TL_HOST_SRC_WIDTH,
  parameter int unsigned IDX_W           = $clog2(NUM_HOSTS),
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [NUM_HOSTS-1:0]    h_a_valid,
  output logic [NUM_HOSTS-1:0]    h_a_ready,
  input  tl_a_t [NUM_HOSTS-1:0]   h_a,
  output logic [NUM_HOSTS-1:0]    h_d_valid,
  input  logic [NUM_HOSTS-1:0]    h_d_ready,
  output tl_d_t [NUM_HOSTS-1:0]   h_d,
  output logic                    m_a_valid,
  input  logic                    m_a_ready,
  output tl_a_t                   m_a,
  input  logic                    m_d_valid,
  output logic                    m_d_ready,
  input  tl_d_t                   m_d,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    err_unroutable
);

  localparam int unsigned SRC_W = HOST_SRC_WIDTH + IDX_W;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  tl_a_t            a_sel;
  logic             a_sel_valid;
  logic             a_hs, d_hs;
  logic [IDX_W-1:0] d_idx;
  logic             d_routable;
  logic             unused_a_src;

  tl_rr_picker #(
    .NUM_HOSTS (NUM_HOSTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req       (h_a_valid),
    .rr_ptr    (rr_ptr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Mux the granted host's A payload and valid.
  always_comb begin
    a_sel       = h_a[0];
    a_sel_valid = h_a_valid[0];
    for (int i = 0; i < NUM_HOSTS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        a_sel       = h_a[i];
        a_sel_valid = h_a_valid[i];
      end
    end
  end

  // Upstream source MSBs are replaced by the grant index, so they are not forwarded.
  assign unused_a_src = ^a_sel.source;

  always_comb begin
    m_a        = a_sel;
    m_a.source = TL_SOURCE_WIDTH'({grant_idx_q, a_sel.source[HOST_SRC_WIDTH-1:0]});
  end

  // Arbiter FSM: next state, grant/pointer updates and A handshake outputs.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    m_a_valid   = 1'b0;
    h_a_ready   = '0;
    case (state_q)
      StIdle: begin
        if (pick_any && (outstanding_q < CNT_W'(MAX_OUTSTANDING))) begin
          state_d     = StGrant;
          grant_idx_d = pick_idx;
        end
      end
      StGrant: begin
        m_a_valid = a_sel_valid;
        for (int i = 0; i < NUM_HOSTS; i++) begin
          h_a_ready[i] = (grant_idx_q == IDX_W'(i)) && m_a_ready;
        end
        // Grant is held until the handshake, even if the host drops valid.
        if (a_sel_valid && m_a_ready) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_HOSTS - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // D routing: host index sits in the top IDX_W source bits; unroutable beats are sunk.
  always_comb begin
    d_idx      = m_d.source[SRC_W-1 -: IDX_W];
    d_routable = 32'(d_idx) < NUM_HOSTS;
    m_d_ready  = !d_routable;
    h_d_valid  = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      h_d[i]        = m_d;
      h_d[i].source = TL_SOURCE_WIDTH'(m_d.source[HOST_SRC_WIDTH-1:0]);
      if (d_routable && (d_idx == IDX_W'(i))) begin
        h_d_valid[i] = m_d_valid;
        m_d_ready    = h_d_ready[i];
      end
    end
  end

  // In-flight counter (saturating at zero) and sticky unroutable flag.
  always_comb begin
    a_hs          = m_a_valid && m_a_ready;
    d_hs          = m_d_valid && m_d_ready;
    outstanding_d = outstanding_q;
    if (a_hs && !d_hs) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (d_hs && !a_hs && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
    err_d = err_q || (d_hs && !d_routable);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= StIdle;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign outstanding    = outstanding_q;
  assign err_unroutable = err_q;

endmodule

// File: tb/tb_tilelink_host_arbiter.sv
// Scoreboard bench for tilelink_host_arbiter (3 hosts, 8 credits).
module tb_tilelink_host_arbiter;
  import tilelink_pkg::*;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [2:0]    h_a_valid;
  logic [2:0]    h_a_ready;
  tl_a_t [2:0]   h_a;
  logic [2:0]    h_d_valid;
  logic [2:0]    h_d_ready;
  tl_d_t [2:0]   h_d;
  logic          m_a_valid;
  logic          m_a_ready;
  tl_a_t         m_a;
  logic          m_d_valid;
  logic          m_d_ready;
  tl_d_t         m_d;
  logic [3:0]    outstanding;
  logic          err_unroutable;

  tilelink_host_arbiter #(
    .NUM_HOSTS       (3),
    .HOST_SRC_WIDTH  (1),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .h_a_valid      (h_a_valid),
    .h_a_ready      (h_a_ready),
    .h_a            (h_a),
    .h_d_valid      (h_d_valid),
    .h_d_ready      (h_d_ready),
    .h_d            (h_d),
    .m_a_valid      (m_a_valid),
    .m_a_ready      (m_a_ready),
    .m_a            (m_a),
    .m_d_valid      (m_d_valid),
    .m_d_ready      (m_d_ready),
    .m_d            (m_d),
    .outstanding    (outstanding),
    .err_unroutable (err_unroutable)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_a_t;

  typedef struct {
    int          host;
    logic [2:0]  src;
    logic [31:0] data;
  } exp_d_t;

  exp_a_t exp_a_q[$];
  exp_d_t exp_d_q[$];
  int     hs_cyc_q[$];
  int     errors = 0;
  int     checks = 0;
  int     a_hs_cnt = 0;
  int     cyc = 0;

  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Host i presents address 0x1000*(i+1), data 0xA0+i, local source i%2.
  task automatic push_a(input int host);
    exp_a_t e;
    logic [1:0] hi;
    hi     = 2'(host);
    e.src  = {hi, 1'(host % 2)};
    e.addr = 32'h1000 * 32'(host + 1);
    e.data = 32'hA0 + 32'(host);
    exp_a_q.push_back(e);
  endtask

  task automatic send_d(input int host, input logic src, input logic [31:0] data);
    exp_d_t e;
    logic [1:0] hi;
    hi           = 2'(host);
    m_d          = '0;
    m_d.opcode   = 3'd1;
    m_d.source   = {hi, src};
    m_d.data     = data;
    m_d_valid    = 1'b1;
    if (host < 3) begin
      e.host = host;
      e.src  = {2'b00, src};
      e.data = data;
      exp_d_q.push_back(e);
    end
    step(1);
    m_d_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (a_hs_cnt < target && n < 100) begin
      step(1);
      n++;
    end
    chk("hs_wait", 32'(a_hs_cnt >= target), 32'd1);
  endtask

  // A-channel monitor: pop expected beat on every downstream handshake.
  always @(negedge clk_in) begin
    exp_a_t e;
    if (!reset_in && m_a_valid && m_a_ready) begin
      hs_cyc_q.push_back(cyc);
      a_hs_cnt++;
      if (exp_a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: source %0h address %0h", m_a.source, m_a.address);
      end else begin
        e = exp_a_q.pop_front();
        chk("a_source", 32'(m_a.source), 32'(e.src));
        chk("a_address", m_a.address, e.addr);
        chk("a_data", m_a.data, e.data);
      end
    end
  end

  // D-channel monitor: pop expected delivery on every host handshake.
  always @(negedge clk_in) begin
    exp_d_t e;
    if (!reset_in) begin
      for (int i = 0; i < 3; i++) begin
        if (h_d_valid[i] && h_d_ready[i]) begin
          if (exp_d_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d_unexpected: host %0d data %0h", i, h_d[i].data);
          end else begin
            e = exp_d_q.pop_front();
            chk("d_host", 32'(i), 32'(e.host));
            chk("d_source", 32'(h_d[i].source), 32'(e.src));
            chk("d_data", h_d[i].data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in  = 1'b1;
    h_a_valid = '0;
    h_d_ready = 3'b111;
    m_a_ready = 1'b0;
    m_d_valid = 1'b0;
    m_d       = '0;
    for (int i = 0; i < 3; i++) begin
      h_a[i]         = '0;
      h_a[i].opcode  = 3'd4;
      h_a[i].size    = 3'd2;
      h_a[i].mask    = 4'hF;
      h_a[i].source  = 3'(i % 2);
      h_a[i].address = 32'h1000 * 32'(i + 1);
      h_a[i].data    = 32'hA0 + 32'(i);
    end
    step(2);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_m_a_valid", 32'(m_a_valid), 32'd0);
    chk("rst_h_a_ready", 32'(h_a_ready), 32'd0);
    chk("rst_err", 32'(err_unroutable), 32'd0);
    reset_in = 1'b0;

    // Round-robin fairness: 0,1,2,0 with one bubble between beats.
    hs_cyc_q.delete();
    push_a(0); push_a(1); push_a(2); push_a(0);
    m_a_ready = 1'b1;
    h_a_valid = 3'b111;
    wait_hs(4);
    h_a_valid = '0;
    chk("rr_hs_count", 32'(hs_cyc_q.size()), 32'd4);
    for (int k = 0; k < 3 && k + 1 < hs_cyc_q.size(); k++) begin
      chk("rr_gap", 32'(hs_cyc_q[k+1] - hs_cyc_q[k]), 32'd2);
    end
    chk("rr_outstanding", 32'(outstanding), 32'd4);
    send_d(0, 1'b0, 32'hD000_0001);
    send_d(1, 1'b1, 32'hD000_0002);
    send_d(2, 1'b0, 32'hD000_0003);
    send_d(0, 1'b0, 32'hD000_0004);
    chk("drain1_outstanding", 32'(outstanding), 32'd0);

    // Back-pressure: host 1 holds the grant while host 0 waits.
    m_a_ready = 1'b0;
    h_a_valid = 3'b010;
    step(1);
    h_a_valid = 3'b011;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_m_a_valid", 32'(m_a_valid), 32'd1);
      chk("bp_grant_idx", 32'(m_a.source[2:1]), 32'd1);
      chk("bp_h_a_ready", 32'(h_a_ready), 32'd0);
      step(1);
    end
    h_a_valid = 3'b001;
    #1;
    chk("drop_m_a_valid", 32'(m_a_valid), 32'd0);
    step(1);
    chk("drop_grant_held", 32'(m_a.source[2:1]), 32'd1);
    h_a_valid = 3'b011;
    push_a(1); push_a(0);
    m_a_ready = 1'b1;
    #1;
    chk("bp_h_a_ready_rel", 32'(h_a_ready), 32'b010);
    wait_hs(6);
    h_a_valid = '0;
    chk("bp_outstanding", 32'(outstanding), 32'd2);
    send_d(1, 1'b1, 32'hD000_0005);
    send_d(0, 1'b0, 32'hD000_0006);

    // Credit limit: eight beats, then stall until a D beat frees a credit.
    push_a(1); push_a(2); push_a(0); push_a(1);
    push_a(2); push_a(0); push_a(1); push_a(2);
    h_a_valid = 3'b111;
    wait_hs(14);
    chk("cr_outstanding8", 32'(outstanding), 32'd8);
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("cr_stall_valid", 32'(m_a_valid), 32'd0);
    end
    push_a(0);
    send_d(1, 1'b0, 32'hD000_0007);
    chk("cr_outstanding7", 32'(outstanding), 32'd7);
    wait_hs(15);
    h_a_valid = '0;
    chk("cr_outstanding_refill", 32'(outstanding), 32'd8);
    for (int k = 0; k < 5; k++) begin
      send_d(k % 3, 1'b1, 32'hD100_0000 + 32'(k));
    end
    chk("cr_outstanding3", 32'(outstanding), 32'd3);

    // Simultaneous A and D handshakes leave the count unchanged.
    push_a(1);
    h_a_valid = 3'b010;
    step(1);
    send_d(0, 1'b1, 32'hD200_0000);
    h_a_valid = '0;
    chk("sim_outstanding", 32'(outstanding), 32'd3);
    send_d(0, 1'b0, 32'hD200_0001);
    send_d(1, 1'b0, 32'hD200_0002);
    send_d(2, 1'b1, 32'hD200_0003);
    chk("drain_outstanding0", 32'(outstanding), 32'd0);
    send_d(0, 1'b0, 32'hD200_0004);
    chk("sat_outstanding0", 32'(outstanding), 32'd0);

    // D routing and ready passthrough to host 2.
    h_d_ready = 3'b011;
    m_d       = '0;
    m_d.source = 3'b100;
    m_d.data   = 32'hCAFE_0002;
    m_d_valid  = 1'b1;
    #1;
    chk("rt_h_d_valid", 32'(h_d_valid), 32'b100);
    chk("rt_h_d2_source", 32'(h_d[2].source), 32'd0);
    chk("rt_h_d0_data", h_d[0].data, 32'hCAFE_0002);
    chk("rt_m_d_ready_lo", 32'(m_d_ready), 32'd0);
    h_d_ready = 3'b100;
    #1;
    chk("rt_m_d_ready_hi", 32'(m_d_ready), 32'd1);
    m_d_valid = 1'b0;
    h_d_ready = 3'b111;

    // Unroutable index 3: dropped, sticky error.
    step(1);
    h_d_ready  = 3'b000;
    m_d.source = 3'b111;
    m_d_valid  = 1'b1;
    #1;
    chk("ur_m_d_ready", 32'(m_d_ready), 32'd1);
    chk("ur_h_d_valid", 32'(h_d_valid), 32'd0);
    chk("ur_err_before", 32'(err_unroutable), 32'd0);
    step(1);
    m_d_valid = 1'b0;
    h_d_ready = 3'b111;
    chk("ur_err_set", 32'(err_unroutable), 32'd1);
    chk("ur_outstanding", 32'(outstanding), 32'd0);
    step(2);
    chk("ur_err_held", 32'(err_unroutable), 32'd1);

    // Reset mid-grant abandons the pending beat; arbitration restarts at host 0.
    push_a(1);
    h_a_valid = 3'b010;
    wait_hs(17);
    h_a_valid = '0;
    chk("rg_outstanding1", 32'(outstanding), 32'd1);
    m_a_ready = 1'b0;
    h_a_valid = 3'b110;
    step(1);
    #1;
    chk("rg_granted2", 32'(m_a.source[2:1]), 32'd2);
    chk("rg_m_a_valid", 32'(m_a_valid), 32'd1);
    #1;
    reset_in = 1'b1;
    #1;
    chk("rg_async_valid", 32'(m_a_valid), 32'd0);
    chk("rg_async_ready", 32'(h_a_ready), 32'd0);
    chk("rg_async_outstanding", 32'(outstanding), 32'd0);
    chk("rg_async_err", 32'(err_unroutable), 32'd0);
    step(1);
    h_a_valid = 3'b111;
    m_a_ready = 1'b1;
    push_a(0);
    reset_in = 1'b0;
    wait_hs(18);
    h_a_valid = '0;
    chk("rg_outstanding_after", 32'(outstanding), 32'd1);

    step(2);
    chk("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    chk("d_queue_empty", 32'(exp_d_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
